// File: rtl/sseg_pkg.sv
// sseg_pkg: shared widths, segment constants and hex-to-segment lookup for the scan controller
// Segment bit order is {g,f,e,d,c,b,a}, active-low (common-anode display).
package sseg_pkg;
  localparam int SEG_W = 7;
  localparam int DIGITS = 4;
  typedef logic [SEG_W-1:0] seg_t;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;
  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction
endpackage

// File: rtl/sseg_scan_controller_if.sv
// sseg_scan_controller_if: value load strobe in, scanned digit select/cathodes/status out
// master: drives value_in/load, observes select, seg, frame_done, pending.
// slave : the scan controller side.
interface sseg_scan_controller_if;
  import sseg_pkg::*;
  logic [15:0] value_in;
  logic load;
  logic [$clog2(DIGITS)-1:0] select;
  seg_t seg;
  logic frame_done;
  logic pending;
  modport master (output value_in, load, input select, seg, frame_done, pending);
  modport slave (input value_in, load, output select, seg, frame_done, pending);
endinterface

// File: rtl/sseg_hex_encoder.sv
// sseg_hex_encoder: combinational 4-bit nibble to active-low gfedcba segment pattern
// Ports: nibble (4) in, seg (7) out.
module sseg_hex_encoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);
  assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/sseg_scan_controller.sv
// sseg_scan_controller: round-robin 4-digit seven-segment refresh with frame-aligned double buffering
// Ports: clk, rst_n (async, active-low), bus (slave modport: value_in, load, select, seg, frame_done, pending).
// Optional: define SSEG_LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module sseg_scan_controller
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input logic clk,
  input logic rst_n,
  sseg_scan_controller_if.slave bus
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  logic [CNT_W-1:0] prescaler;
  logic [$clog2(DIGITS)-1:0] select;
  logic [15:0] display_reg, pending_reg;
  logic pending, frame_done, tick, wrap, blank;
  logic [3:0] nibble;
  seg_t hex_seg;
  assign tick = prescaler == CNT_W'(REFRESH_DIV - 1);
  assign wrap = tick && select == 2'd3;
  assign nibble = display_reg[{select, 2'b00} +: 4];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      select <= '0;
      display_reg <= '0;
      pending_reg <= '0;
      pending <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      select <= tick ? select + 1'b1 : select;
      frame_done <= wrap;
      // A load coinciding with the frame boundary bypasses the buffer so the newest value wins.
      display_reg <= wrap ? (bus.load ? bus.value_in : (pending ? pending_reg : display_reg)) : display_reg;
      pending_reg <= (!wrap && bus.load) ? bus.value_in : pending_reg;
      pending <= wrap ? 1'b0 : (bus.load ? 1'b1 : pending);
    end
  end
  sseg_hex_encoder u_enc (.nibble(nibble), .seg(hex_seg));
`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // Digit k is blank when it and every higher nibble are zero; digit 0 always shows.
  assign blank = select != 2'd0 && (display_reg >> {select, 2'b00}) == 16'h0;
`else
  assign blank = 1'b0;
`endif
  assign bus.select = select;
  assign bus.seg = blank ? SEG_BLANK : hex_seg;
  assign bus.frame_done = frame_done;
  assign bus.pending = pending;
endmodule
